// File: rtl/phase_ref_sequencer_pkg.sv
// Shared types, the staircase table and index/clip helpers for the phase sequencer.
package phase_ref_sequencer_pkg;

  localparam int unsigned LVL_W   = 3;
  localparam int unsigned N_STEPS = 12;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned OFS_1   = 4;
  localparam int unsigned OFS_2   = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef logic signed [LVL_W-1:0] level_t;

  // One electrical period of the staircase sine, phase A at idx.
  localparam level_t BASE_T [N_STEPS] = '{
    3'sd0,  3'sd2,  3'sd3,  3'sd3,  3'sd3,  3'sd2,
    3'sd0, -3'sd2, -3'sd3, -3'sd3, -3'sd3, -3'sd2
  };

  // (i + ofs) mod N_STEPS for in-range operands.
  function automatic logic [IDX_W-1:0] idx_add(logic [IDX_W-1:0] i, logic [IDX_W-1:0] ofs);
    logic [IDX_W:0] s;
    s = {1'b0, i} + {1'b0, ofs};
    if (s >= (IDX_W+1)'(N_STEPS)) s = s - (IDX_W+1)'(N_STEPS);
    return s[IDX_W-1:0];
  endfunction

  // sign(x) * min(|x|, a); symmetric, so -4 can never appear.
  function automatic level_t clip_level(level_t x, logic [1:0] a);
    level_t lim;
    lim = $signed({1'b0, a});
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

endpackage

// File: rtl/phase_ref_sequencer_step_prescaler.sv
// Clocks-per-step divider: counts 0..period-1 while enabled and flags the last count.
module phase_ref_sequencer_step_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt;

  // period is never 0 here; the top substitutes 1 before latching.
  assign tick_c = en && (cnt == period - DIV_W'(1));

  // Counter clears on load and on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clr || tick_c)  cnt <= '0;
    else if (en)             cnt <= cnt + DIV_W'(1);
  end

endmodule

// File: rtl/phase_ref_sequencer.sv
// Three-phase staircase sine sequencer with rate, direction, clip and drain-to-zero stop.
module phase_ref_sequencer
  import phase_ref_sequencer_pkg::*;
#(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned STEPS = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             dir,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       amp,
  output logic [2:0]       PhA,
  output logic [2:0]       PhB,
  output logic [2:0]       PhC,
  output logic             busy,
  output logic             step_stb,
  output logic             per_stb
);

  state_t           state_q, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [1:0]       amp_q, amp_n;
  logic             dir_q, dir_n;
  logic             clr_c, en_c, tick_c;
  logic             busy_n, step_n, per_n;
  level_t           pha_n, phb_n, phc_n;
  logic [IDX_W-1:0] ofs_b, ofs_c;

  phase_ref_sequencer_step_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk    (clk),
    .rst_n  (rst),
    .clr    (clr_c),
    .en     (en_c),
    .period (div_q),
    .tick_c (tick_c)
  );

  // Next state, latched settings and next output values.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    div_n   = div_q;
    amp_n   = amp_q;
    dir_n   = dir_q;
    clr_c   = 1'b0;
    en_c    = 1'b0;
    step_n  = 1'b0;
    per_n   = 1'b0;
    pha_n   = '0;
    phb_n   = '0;
    phc_n   = '0;
    ofs_b   = '0;
    ofs_c   = '0;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_n = RUN;
          idx_n   = '0;
          clr_c   = 1'b1;
          div_n   = (div == '0) ? DIV_W'(1) : div;
          amp_n   = amp;
          dir_n   = dir;
        end
      end
      RUN, DRAIN: begin
        en_c = 1'b1;
        if (tick_c) begin
          step_n = 1'b1;
          amp_n  = amp;
          if (idx_q == IDX_W'(STEPS - 1)) begin
            // Rate and direction only change on a period boundary.
            idx_n = '0;
            per_n = 1'b1;
            div_n = (div == '0) ? DIV_W'(1) : div;
            dir_n = dir;
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end
        if (run)
          state_n = RUN;
        else if (state_q == RUN)
          state_n = DRAIN;
        else if (tick_c && (idx_n == '0 || idx_n == IDX_W'(STEPS / 2)))
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
    ofs_b  = dir_n ? IDX_W'(OFS_1) : IDX_W'(OFS_2);
    ofs_c  = dir_n ? IDX_W'(OFS_2) : IDX_W'(OFS_1);
    if (busy_n) begin
      pha_n = clip_level(BASE_T[idx_n], amp_n);
      phb_n = clip_level(BASE_T[idx_add(idx_n, ofs_b)], amp_n);
      phc_n = clip_level(BASE_T[idx_add(idx_n, ofs_c)], amp_n);
    end
  end

  // State, settings and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      div_q    <= DIV_W'(1);
      amp_q    <= '0;
      dir_q    <= 1'b0;
      PhA      <= '0;
      PhB      <= '0;
      PhC      <= '0;
      busy     <= 1'b0;
      step_stb <= 1'b0;
      per_stb  <= 1'b0;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      div_q    <= div_n;
      amp_q    <= amp_n;
      dir_q    <= dir_n;
      PhA      <= pha_n;
      PhB      <= phb_n;
      PhC      <= phc_n;
      busy     <= busy_n;
      step_stb <= step_n;
      per_stb  <= per_n;
    end
  end

endmodule
